ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, XLEN-parametrised.
//  Sits beside the combinational EX ALU; EX routes M-ops here and freezes the pipeline via stallreq_o.
//  Radix-2 shift-add multiply / restoring divide, one bit per cycle; special divide cases finish early.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, even)
//  REGADDR_W   5   destination register index width
// PORTS
//  clk         in   1          clock
//  rst         in   1          reset; synchronous, active-low
//  start_i     in   1          launch op; sampled only in IDLE
//  flush_i     in   1          abort current op (branch mispredict)
//  op_i        in   3          funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  reg1_i      in   XLEN       rs1 value
//  reg2_i      in   XLEN       rs2 value
//  wd_i        in   REGADDR_W  destination register
//  wreg_i      in   1          write-enable of the instruction
//  stallreq_o  out  1          pipeline stall request
//  done_o      out  1          result valid, one-cycle pulse
//  wdata_o     out  XLEN       result, valid when done_o
//  wd_o        out  REGADDR_W  destination captured at start
//  wreg_o      out  1          wreg captured at start, AND-ed with done_o
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE; done_o=0, wdata_o=0, wd_o=0, wreg_o=0, counter=0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE; IDLE -> DONE on special case.
//  IDLE: start_i=1 captures op/wd/wreg and |operands| per signedness (MULHSU: rs1 signed, rs2 unsigned);
//    computes result sign; counter<=0; -> CALC.
//  Special cases (detected in IDLE, -> DONE directly, latency 1):
//    divisor==0: DIV/DIVU result all-ones; REM/REMU result = rs1.
//    DIV: rs1==most-negative && rs2==-1 -> result rs1; REM same case -> 0.
//  CALC: one partial product / quotient bit per cycle; exactly XLEN cycles; counter wraps to 0 on exit.
//  FIX: two's-complement negate if result sign set; select low half (MUL), high half (MULH*),
//    quotient or remainder. REM sign follows dividend; DIV sign = sign(rs1)^sign(rs2).
//  DONE: done_o=1 for one cycle; wdata_o/wd_o/wreg_o valid; -> IDLE. start_i ignored in DONE.
//  Latency: start in cycle 0 -> done_o in cycle XLEN+2 (34 for XLEN=32); special case -> cycle 1.
//  stallreq_o = (IDLE & start_i & ~flush_i) | CALC | FIX; low in DONE so EX advances and
//    captures the result the same cycle. Combinational from start_i only in IDLE.
//  start_i while CALC/FIX/DONE: ignored, operands not re-sampled.
//  flush_i: any state -> IDLE next edge, no done_o; flush wins over simultaneous start_i.
//  Reset mid-operation: identical to flush; no partial result escapes.
//  Internal widths: product accumulator 2*XLEN; remainder XLEN+1 bits for the trial subtraction.
// STRUCTURE
//  Shared defines header: MD_OP_* funct3 codes, MD_IDLE/CALC/FIX/DONE state codes, width macros.
//  One sub-module: ex_muldiv_core (shift-add/subtract datapath, one step per enable);
//    FSM, sign pre/post-processing, special-case detection in ex_muldiv.
// TESTING
//  MUL 7 * -3 (start cycle 0) -> done_o cycle 34, wdata_o=0xFFFFFFEB; stallreq_o high cycles 0-33.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF;
//    MULHU same operands -> 0xFFFFFFFE.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both done_o in cycle 1;
//    DIV 0x80000000/-1 -> 0x80000000, REM -> 0, done_o in cycle 1.
//  flush_i in cycle 10 of MUL -> no done_o, stallreq_o low from cycle 11; new DIV started
//    in cycle 12 completes correctly in cycle 46.
//  rst=0 in cycle 5 of DIV -> all outputs 0 next cycle; start_i while busy ignored (result unchanged).
//  wreg_i=0 op -> done_o=1, wreg_o=0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the iterative RV M-extension unit: funct3 op codes, FSM states
// and op-classification helpers used by the sequencer.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'b000,
    MD_OP_MULH   = 3'b001,
    MD_OP_MULHSU = 3'b010,
    MD_OP_MULHU  = 3'b011,
    MD_OP_DIV    = 3'b100,
    MD_OP_DIVU   = 3'b101,
    MD_OP_REM    = 3'b110,
    MD_OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL needs no sign handling: the low half of the product is sign-agnostic.
  function automatic logic md_rs1_signed(input md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic md_rs2_signed(input md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
// hi/lo hold product high/low halves, or remainder/quotient when dividing.
module ex_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            div_q, div_d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    div_d   = div_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, b_q};
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
    end else if (step_i) begin
      if (div_q) begin
        // A clear top bit means the trial subtraction did not borrow: keep it, quotient bit 1.
        if (!trial[XLEN]) begin
          hi_d = trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before the FSM reads them.
  always_ff @(posedge clk) begin
    hi_q  <= hi_d;
    lo_q  <= lo_d;
    b_q   <= b_d;
    div_q <= div_d;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension unit beside the EX ALU: sequencing FSM, sign pre/post
// processing and early-out special divide cases around the unsigned core.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [2:0]           op_i,
  input  logic [XLEN-1:0]      reg1_i,
  input  logic [XLEN-1:0]      reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  output logic                 stallreq_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      wdata_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e            state_q, state_d;
  md_op_e               op_q, op_d;
  logic [REGADDR_W-1:0] wd_q, wd_d;
  logic                 wreg_q, wreg_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  md_op_e              op_in;
  logic                s1, s2, neg_in, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic                core_load, core_step;
  logic [XLEN-1:0]     core_hi, core_lo;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

  assign op_in = md_op_e'(op_i);

  always_comb begin
    s1     = md_rs1_signed(op_in) & reg1_i[XLEN-1];
    s2     = md_rs2_signed(op_in) & reg2_i[XLEN-1];
    a_mag  = s1 ? -reg1_i : reg1_i;
    b_mag  = s2 ? -reg2_i : reg2_i;
    // The remainder takes the dividend's sign; everything else the product of signs.
    unique case (op_in)
      MD_OP_MULH, MD_OP_DIV:   neg_in = s1 ^ s2;
      MD_OP_MULHSU, MD_OP_REM: neg_in = s1;
      default:                 neg_in = 1'b0;
    endcase
    special     = 1'b0;
    special_res = '0;
    if (md_is_div(op_in)) begin
      if (reg2_i == '0) begin
        special     = 1'b1;
        special_res = md_is_rem(op_in) ? reg1_i : '1;
      end else if ((op_in inside {MD_OP_DIV, MD_OP_REM}) &&
                   reg1_i == MOST_NEG && reg2_i == '1) begin
        special     = 1'b1;
        special_res = (op_in == MD_OP_REM) ? '0 : reg1_i;
      end
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    quot_fix = neg_q ? -core_lo : core_lo;
    rem_fix  = neg_q ? -core_hi : core_hi;
    unique case (op_q)
      MD_OP_MUL:                            fix_res = prod_fix[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:                fix_res = quot_fix;
      default:                              fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          op_d   = op_in;
          wd_d   = wd_i;
          wreg_d = wreg_i;
          neg_d  = neg_in;
          cnt_d  = '0;
          if (special) begin
            wdata_d = special_res;
            done_d  = 1'b1;
            state_d = MD_DONE;
          end else begin
            core_load = 1'b1;
            state_d   = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        core_step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MD_FIX: begin
        wdata_d = fix_res;
        done_d  = 1'b1;
        state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
    // A flush discards the op in flight; the previous result stays on wdata_o.
    if (flush_i) begin
      state_d   = MD_IDLE;
      done_d    = 1'b0;
      wdata_d   = wdata_q;
      cnt_d     = '0;
      core_load = 1'b0;
      core_step = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_OP_MUL;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  ex_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (md_is_div(op_in)),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  assign stallreq_o = (state_q == MD_IDLE && start_i && !flush_i) ||
                      state_q == MD_CALC || state_q == MD_FIX;
  assign done_o     = done_q;
  assign wdata_o    = wdata_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q & done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, flush/reset abort and
// randomized ops compared against a plain-arithmetic reference model.
module tb_ex_muldiv;

  localparam int XLEN = 32;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              flush_i;
  logic [2:0]        op_i;
  logic [XLEN-1:0]   reg1_i;
  logic [XLEN-1:0]   reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic              stallreq_o;
  logic              done_o;
  logic [XLEN-1:0]   wdata_o;
  logic [4:0]        wd_o;
  logic              wreg_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.XLEN(XLEN), .REGADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .op_i       (op_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    int          ia, ib;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub_s = longint'({32'd0, b});
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ia   = $signed(a);
    ib   = $signed(b);
    p    = 64'd0;
    case (op)
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op in the current cycle and follows it to done_o, checking
  // latency, result, destination tag and the stall profile along the way.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                        input logic noise);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    int          stall_err;
    logic        seen;
    exp       = model(op, a, b);
    exp_lat   = is_special(op, a, b) ? 1 : XLEN + 2;
    op_i      = op;
    reg1_i    = a;
    reg2_i    = b;
    wd_i      = wd;
    wreg_i    = wreg;
    start_i   = 1'b1;
    #1;
    check({tag, ".stall_c0"}, {63'd0, stallreq_o}, 64'd1);
    lat       = 0;
    seen      = 1'b0;
    stall_err = 0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_o) begin
        seen = 1'b1;
        if (stallreq_o !== 1'b0) stall_err++;
      end else begin
        if (stallreq_o !== 1'b1) stall_err++;
        start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          op_i   = 3'($urandom);
          reg1_i = $urandom;
          reg2_i = $urandom;
          wd_i   = 5'($urandom);
        end
      end
    end
    start_i = 1'b0;
    if (!seen) lat = -1;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".wdata"}, {32'd0, wdata_o}, {32'd0, exp});
    check({tag, ".wd"}, {59'd0, wd_o}, {59'd0, wd});
    check({tag, ".wreg"}, {63'd0, wreg_o}, {63'd0, wreg});
    check({tag, ".stall_profile"}, 64'(stall_err), 64'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    int spurious;
    rst     = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 3'd0;
    reg1_i  = '0;
    reg2_i  = '0;
    wd_i    = '0;
    wreg_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.done", {63'd0, done_o}, 64'd0);
    check("reset.wdata", {32'd0, wdata_o}, 64'd0);
    check("reset.wd", {59'd0, wd_o}, 64'd0);
    check("reset.wreg", {63'd0, wreg_o}, 64'd0);
    check("reset.stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  1'b1, 1'b0);
    run_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  1'b1, 1'b0);
    run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b1, 1'b0);
    run_op("mulhu_m1",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  1'b1, 1'b0);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  1'b1, 1'b0);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  1'b1, 1'b0);
    run_op("divu_max_2",  3'd5, 32'hFFFF_FFFF,  32'd2,         5'd7,  1'b1, 1'b0);
    run_op("divu_by0",    3'd5, 32'd5,          32'd0,         5'd8,  1'b1, 1'b0);
    run_op("rem_by0",     3'd6, 32'd5,          32'd0,         5'd9,  1'b1, 1'b0);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1'b1, 1'b0);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0);
    run_op("nowreg",      3'd0, 32'd12345,      32'd678,       5'd12, 1'b0, 1'b0);
    run_op("busy_noise",  3'd7, 32'hDEAD_BEEF,  32'd1000,      5'd13, 1'b1, 1'b1);

    // Flush in cycle 10 of a MUL, then a DIV launched in cycle 12.
    op_i    = 3'd0;
    reg1_i  = 32'd99;
    reg2_i  = 32'd77;
    wd_i    = 5'd14;
    wreg_i  = 1'b1;
    start_i = 1'b1;
    spurious = 0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done_o) spurious++;
      @(posedge clk);
      #1;
    end
    check("flush.stall_c10", {63'd0, stallreq_o}, 64'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    if (done_o) spurious++;
    check("flush.stall_c11", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk);
    #1;
    if (done_o) spurious++;
    check("flush.no_done", 64'(spurious), 64'd0);
    run_op("after_flush_div", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd15, 1'b1, 1'b0);

    // Leave a non-zero result and tag on the outputs, then reset in cycle 5 of a DIV.
    run_op("pre_reset", 3'd5, 32'hFFFF_FFFF, 32'd2, 5'd17, 1'b1, 1'b0);
    op_i    = 3'd4;
    reg1_i  = 32'd100;
    reg2_i  = 32'd7;
    wd_i    = 5'd18;
    wreg_i  = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst.done", {63'd0, done_o}, 64'd0);
    check("midrst.wdata", {32'd0, wdata_o}, 64'd0);
    check("midrst.wd", {59'd0, wd_o}, 64'd0);
    check("midrst.wreg", {63'd0, wreg_o}, 64'd0);
    check("midrst.stall", {63'd0, stallreq_o}, 64'd0);
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_o || stallreq_o) spurious++;
    end
    check("midrst.quiet", 64'(spurious), 64'd0);

    // Flush wins over a simultaneous start in IDLE.
    op_i    = 3'd1;
    reg1_i  = 32'd3;
    reg2_i  = 32'd4;
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("flush_start.stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || stallreq_o) spurious++;
      @(posedge clk);
      #1;
    end
    check("flush_start.quiet", 64'(spurious), 64'd0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom), pick(), pick(),
             5'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
